// File: rtl/ga_pkg.sv
// Shared types and the fitness ordering used by the tournament buffer.
package ga_pkg;

  // Widest fitness the comparison helper accepts; callers zero-extend into it.
  localparam int unsigned FIT_MAX_W = 128;

  typedef logic [FIT_MAX_W-1:0] fit_ext_t;

  typedef enum logic [1:0] {
    ST_FILL,
    ST_EMIT,
    ST_DONE
  } ga_state_e;

  // True when fitness a is strictly better than b under the selected direction.
  function automatic logic fit_better(input logic maximize, input fit_ext_t a, input fit_ext_t b);
    return maximize ? (a > b) : (a < b);
  endfunction

endpackage

// File: rtl/ga_winner_mem.sv
// Winner slot storage: one write port, one read port with a registered output.
module ga_winner_mem #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 67
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Storage array write; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Read register holds its value when no read is requested, giving a stable output.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/ga_tournament_buf.sv
// Pairwise tournament buffer: collects a generation, keeps pair winners, streams them out.
module ga_tournament_buf
  import ga_pkg::*;
#(
  parameter int unsigned POP_SIZE      = 32,
  parameter int unsigned CHROM_WIDTH   = 16,
  parameter int unsigned FITNESS_WIDTH = (CHROM_WIDTH + 1) * 3,
  parameter int unsigned GENS          = 100,
  parameter bit          MAXIMIZE      = 1'b0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHROM_WIDTH-1:0]     in_chrom,
  input  logic [FITNESS_WIDTH-1:0]   in_fit,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CHROM_WIDTH-1:0]     out_chrom,
  output logic [FITNESS_WIDTH-1:0]   out_fit,
  output logic [CHROM_WIDTH-1:0]     best_chrom,
  output logic [FITNESS_WIDTH-1:0]   best_fit,
  output logic                       best_valid,
  output logic [$clog2(GENS+1)-1:0]  gen_count,
  output logic                       done
);

  localparam int unsigned SLOTS  = POP_SIZE / 2;
  localparam int unsigned IDX_W  = $clog2(POP_SIZE);
  localparam int unsigned SLOT_W = $clog2(SLOTS);
  localparam int unsigned ENT_W  = CHROM_WIDTH + FITNESS_WIDTH;
  localparam int unsigned GEN_W  = $clog2(GENS + 1);

  ga_state_e                state_q, state_d;
  logic [IDX_W-1:0]         idx_q;
  logic [SLOT_W-1:0]        slot_q;
  logic [CHROM_WIDTH-1:0]   even_chrom_q;
  logic [FITNESS_WIDTH-1:0] even_fit_q;
  logic [CHROM_WIDTH-1:0]   best_chrom_q;
  logic [FITNESS_WIDTH-1:0] best_fit_q;
  logic                     best_valid_q;
  logic [GEN_W-1:0]         gen_q;

  logic             in_fire, out_fire, last_in, last_slot, gen_last, even_wins, new_best;
  logic [GEN_W-1:0] gen_inc;
  logic             wr_en, rd_en;
  logic [SLOT_W-1:0] wr_addr, rd_addr;
  logic [ENT_W-1:0] wr_data, rd_data;

  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign last_in   = (idx_q == IDX_W'(POP_SIZE - 1));
  assign last_slot = (slot_q == SLOT_W'(SLOTS - 1));
  assign gen_inc   = gen_q + GEN_W'(1);
  assign gen_last  = (gen_inc == GEN_W'(GENS));
  assign even_wins = fit_better(MAXIMIZE, fit_ext_t'(even_fit_q), fit_ext_t'(in_fit));
  assign new_best  = !best_valid_q || fit_better(MAXIMIZE, fit_ext_t'(in_fit), fit_ext_t'(best_fit_q));

  // Odd arrivals settle their pair; slot 0 is prefetched on the final accept so
  // the first winner is presented one cycle later, and each transfer prefetches the next slot.
  assign wr_en   = in_fire && idx_q[0];
  assign wr_addr = idx_q[IDX_W-1:1];
  assign wr_data = even_wins ? {even_chrom_q, even_fit_q} : {in_chrom, in_fit};
  assign rd_en   = (in_fire && last_in) || (out_fire && !last_slot);
  assign rd_addr = (state_q == ST_EMIT) ? slot_q + SLOT_W'(1) : '0;

  ga_winner_mem #(
    .DEPTH (SLOTS),
    .ADDR_W(SLOT_W),
    .DATA_W(ENT_W)
  ) u_mem (
    .clk_i    (clk),
    .rst_i    (reset),
    .wr_en_i  (wr_en),
    .wr_addr_i(wr_addr),
    .wr_data_i(wr_data),
    .rd_en_i  (rd_en),
    .rd_addr_i(rd_addr),
    .rd_data_o(rd_data)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_FILL;
    else       state_q <= state_d;
  end

  // Next-state: fill a generation, drain its winners, then refill or stop.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FILL: if (in_fire && last_in) state_d = ST_EMIT;
      ST_EMIT: if (out_fire && last_slot) state_d = gen_last ? ST_DONE : ST_FILL;
      ST_DONE: state_d = ST_DONE;
      default: state_d = ST_FILL;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    in_ready  = (state_q == ST_FILL);
    out_valid = (state_q == ST_EMIT);
    done      = (state_q == ST_DONE);
  end

  // Index, slot pointer, pending even individual, best-ever and generation counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q        <= '0;
      slot_q       <= '0;
      even_chrom_q <= '0;
      even_fit_q   <= '0;
      best_chrom_q <= '0;
      best_fit_q   <= '0;
      best_valid_q <= 1'b0;
      gen_q        <= '0;
    end else begin
      if (in_fire) begin
        idx_q <= last_in ? '0 : idx_q + IDX_W'(1);
        if (!idx_q[0]) begin
          even_chrom_q <= in_chrom;
          even_fit_q   <= in_fit;
        end
        if (new_best) begin
          best_chrom_q <= in_chrom;
          best_fit_q   <= in_fit;
          best_valid_q <= 1'b1;
        end
        if (last_in) slot_q <= '0;
      end
      if (out_fire) begin
        slot_q <= last_slot ? '0 : slot_q + SLOT_W'(1);
        if (last_slot) gen_q <= gen_inc;
      end
    end
  end

  assign out_chrom  = rd_data[ENT_W-1:FITNESS_WIDTH];
  assign out_fit    = rd_data[FITNESS_WIDTH-1:0];
  assign best_chrom = best_chrom_q;
  assign best_fit   = best_fit_q;
  assign best_valid = best_valid_q;
  assign gen_count  = gen_q;

endmodule

// File: tb/tb_ga_tournament_buf.sv
// Bench for ga_tournament_buf: directed POP_SIZE=4 cases (both directions) and a randomized POP_SIZE=32 run.
module tb_ga_tournament_buf;

  localparam int unsigned CW   = 16;
  localparam int unsigned FW   = (CW + 1) * 3;
  localparam int unsigned SP   = 4;
  localparam int unsigned BP   = 32;
  localparam int unsigned SG   = 2;
  localparam int unsigned BG   = 3;
  localparam int unsigned GW_S = $clog2(SG + 1);
  localparam int unsigned GW_B = $clog2(BG + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Shared stimulus for the two small instances (minimize / maximize)
  logic          rst_sm, iv_sm, or_sm;
  logic [CW-1:0] ic_sm;
  logic [FW-1:0] if_sm;
  logic            ir_mn, ov_mn, bv_mn, dn_mn;
  logic [CW-1:0]   oc_mn, bc_mn;
  logic [FW-1:0]   of_mn, bf_mn;
  logic [GW_S-1:0] gc_mn;
  logic            ir_mx, ov_mx, bv_mx, dn_mx;
  logic [CW-1:0]   oc_mx, bc_mx;
  logic [FW-1:0]   of_mx, bf_mx;
  logic [GW_S-1:0] gc_mx;

  // Large instance
  logic            rst_bg, iv_bg, or_bg;
  logic [CW-1:0]   ic_bg;
  logic [FW-1:0]   if_bg;
  logic            ir_bg, ov_bg, bv_bg, dn_bg;
  logic [CW-1:0]   oc_bg, bc_bg;
  logic [FW-1:0]   of_bg, bf_bg;
  logic [GW_B-1:0] gc_bg;

  ga_tournament_buf #(.POP_SIZE(SP), .CHROM_WIDTH(CW), .GENS(SG), .MAXIMIZE(1'b0)) u_mn (
    .clk(clk), .reset(rst_sm), .in_valid(iv_sm), .in_ready(ir_mn), .in_chrom(ic_sm), .in_fit(if_sm),
    .out_valid(ov_mn), .out_ready(or_sm), .out_chrom(oc_mn), .out_fit(of_mn),
    .best_chrom(bc_mn), .best_fit(bf_mn), .best_valid(bv_mn), .gen_count(gc_mn), .done(dn_mn));

  ga_tournament_buf #(.POP_SIZE(SP), .CHROM_WIDTH(CW), .GENS(SG), .MAXIMIZE(1'b1)) u_mx (
    .clk(clk), .reset(rst_sm), .in_valid(iv_sm), .in_ready(ir_mx), .in_chrom(ic_sm), .in_fit(if_sm),
    .out_valid(ov_mx), .out_ready(or_sm), .out_chrom(oc_mx), .out_fit(of_mx),
    .best_chrom(bc_mx), .best_fit(bf_mx), .best_valid(bv_mx), .gen_count(gc_mx), .done(dn_mx));

  ga_tournament_buf #(.POP_SIZE(BP), .CHROM_WIDTH(CW), .GENS(BG), .MAXIMIZE(1'b0)) u_bg (
    .clk(clk), .reset(rst_bg), .in_valid(iv_bg), .in_ready(ir_bg), .in_chrom(ic_bg), .in_fit(if_bg),
    .out_valid(ov_bg), .out_ready(or_bg), .out_chrom(oc_bg), .out_fit(of_bg),
    .best_chrom(bc_bg), .best_fit(bf_bg), .best_valid(bv_bg), .gen_count(gc_bg), .done(dn_bg));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model: instance 0 = minimize small, 1 = maximize small, 2 = large
  logic [CW-1:0]    gin_c [3][BP];
  logic [FW-1:0]    gin_f [3][BP];
  int               gin_n [3];
  logic [CW-1:0]    mb_c [3];
  logic [FW-1:0]    mb_f [3];
  bit               mb_v [3];
  bit               mx_of [3] = '{1'b0, 1'b1, 1'b0};
  logic [CW+FW-1:0] exp_q [3][$];

  function automatic bit tb_better(input bit mx, input logic [FW-1:0] a, input logic [FW-1:0] b);
    return mx ? (a > b) : (a < b);
  endfunction

  task automatic model_reset(input int i);
    gin_n[i] = 0;
    mb_v[i]  = 1'b0;
    mb_c[i]  = '0;
    mb_f[i]  = '0;
    exp_q[i].delete();
  endtask

  // A completed generation is resolved pairwise into the expected winner stream
  task automatic model_accept(input int i, input int pop, input logic [CW-1:0] c, input logic [FW-1:0] f);
    gin_c[i][gin_n[i]] = c;
    gin_f[i][gin_n[i]] = f;
    gin_n[i]++;
    if (!mb_v[i] || tb_better(mx_of[i], f, mb_f[i])) begin
      mb_v[i] = 1'b1;
      mb_c[i] = c;
      mb_f[i] = f;
    end
    if (gin_n[i] == pop) begin
      for (int k = 0; k < pop / 2; k++) begin
        if (tb_better(mx_of[i], gin_f[i][2*k], gin_f[i][2*k+1]))
          exp_q[i].push_back({gin_c[i][2*k], gin_f[i][2*k]});
        else
          exp_q[i].push_back({gin_c[i][2*k+1], gin_f[i][2*k+1]});
      end
      gin_n[i] = 0;
    end
  endtask

  task automatic push_sm(input logic [CW-1:0] c, input logic [FW-1:0] f);
    int n = 0;
    @(negedge clk);
    iv_sm = 1'b1; ic_sm = c; if_sm = f;
    #1;
    while (!ir_mn && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) check("push_timeout", 1, 0);
    else begin
      model_accept(0, SP, c, f);
      model_accept(1, SP, c, f);
    end
    @(posedge clk); #1;
    iv_sm = 1'b0;
  endtask

  task automatic pop_sm(input string tag, output logic [CW-1:0] c_mn, output logic [CW-1:0] c_mx);
    int n = 0;
    logic [CW+FW-1:0] e;
    c_mn = '0; c_mx = '0;
    @(negedge clk);
    or_sm = 1'b1;
    #1;
    while (!ov_mn && n < 20) begin
      @(negedge clk); #1; n++;
    end
    if (n >= 20) check({tag, "_timeout"}, 1, 0);
    else begin
      c_mn = oc_mn; c_mx = oc_mx;
      check({tag, "_mx_valid"}, ov_mx, 1);
      if (exp_q[0].size() == 0) check({tag, "_mn_extra"}, 1, 0);
      else begin
        e = exp_q[0].pop_front();
        check({tag, "_mn_chrom"}, oc_mn, e[CW+FW-1:FW]);
        check({tag, "_mn_fit"}, of_mn, e[FW-1:0]);
      end
      if (exp_q[1].size() == 0) check({tag, "_mx_extra"}, 1, 0);
      else begin
        e = exp_q[1].pop_front();
        check({tag, "_mx_chrom"}, oc_mx, e[CW+FW-1:FW]);
        check({tag, "_mx_fit"}, of_mx, e[FW-1:0]);
      end
    end
    @(posedge clk); #1;
    or_sm = 1'b0;
  endtask

  task automatic check_best_sm(input string tag);
    check({tag, "_mn_bv"}, bv_mn, mb_v[0]);
    check({tag, "_mn_bc"}, bc_mn, mb_c[0]);
    check({tag, "_mn_bf"}, bf_mn, mb_f[0]);
    check({tag, "_mx_bv"}, bv_mx, mb_v[1]);
    check({tag, "_mx_bc"}, bc_mx, mb_c[1]);
    check({tag, "_mx_bf"}, bf_mx, mb_f[1]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [CW-1:0] c0, c1;
    logic [CW+FW-1:0] e;
    int sent, got, cyc;

    rst_sm = 1'b1; iv_sm = 1'b0; or_sm = 1'b0; ic_sm = '0; if_sm = '0;
    rst_bg = 1'b1; iv_bg = 1'b0; or_bg = 1'b0; ic_bg = '0; if_bg = '0;
    for (int i = 0; i < 3; i++) model_reset(i);
    repeat (3) @(negedge clk);
    #1;
    // Reset state
    check("rst_in_ready", ir_mn, 1);
    check("rst_out_valid", ov_mn, 0);
    check("rst_out_chrom", oc_mn, 0);
    check("rst_out_fit", of_mn, 0);
    check("rst_best_valid", bv_mn, 0);
    check("rst_best_chrom", bc_mn, 0);
    check("rst_best_fit", bf_mn, 0);
    check("rst_gen", gc_mn, 0);
    check("rst_done", dn_mn, 0);
    check("rst_mx_best_valid", bv_mx, 0);
    @(negedge clk);
    rst_sm = 1'b0;

    // Generation 1: directed pairs
    push_sm(16'hA1, FW'(5));
    push_sm(16'hB2, FW'(3));
    push_sm(16'hC3, FW'(7));
    push_sm(16'hD4, FW'(7));
    check("latency_mn", ov_mn, 1);
    check("latency_mx", ov_mx, 1);

    // Consumer stall with an offered input that must be ignored
    for (int s = 0; s < 5; s++) begin
      @(negedge clk);
      iv_sm = 1'b1; ic_sm = 16'hEE; if_sm = '0;
      #1;
      check("stall_valid", ov_mn, 1);
      check("stall_mn_chrom", oc_mn, 16'hB2);
      check("stall_mn_fit", of_mn, 3);
      check("stall_mx_chrom", oc_mx, 16'hA1);
      check("stall_in_ready", ir_mn, 0);
    end
    iv_sm = 1'b0;

    pop_sm("g1s0", c0, c1);
    check("g1s0_mn_const", c0, 16'hB2);
    check("g1s0_mx_const", c1, 16'hA1);
    pop_sm("g1s1", c0, c1);
    check("g1s1_mn_const", c0, 16'hD4);
    check("g1s1_mx_const", c1, 16'hD4);
    check("g1_best_mn_const", bc_mn, 16'hB2);
    check("g1_best_mx_const", bc_mx, 16'hC3);
    check_best_sm("g1");
    check("g1_gen", gc_mn, 1);
    check("g1_refill", ir_mn, 1);
    check("g1_done", dn_mn, 0);

    // Generation 2: random fitnesses with frequent ties
    for (int i = 0; i < 4; i++) push_sm(CW'($urandom), FW'($urandom_range(0, 9)));
    pop_sm("g2s0", c0, c1);
    pop_sm("g2s1", c0, c1);
    check("g2_gen", gc_mn, 2);
    check("g2_done", dn_mn, 1);
    check("g2_mx_done", dn_mx, 1);
    check("g2_in_ready", ir_mn, 0);
    check("g2_out_valid", ov_mn, 0);
    check_best_sm("g2");

    // Inputs in DONE must be ignored
    for (int s = 0; s < 4; s++) begin
      @(negedge clk);
      iv_sm = 1'b1; ic_sm = 16'h5555; if_sm = '0; or_sm = 1'b1;
    end
    @(negedge clk);
    iv_sm = 1'b0; or_sm = 1'b0;
    #1;
    check("done_hold", dn_mn, 1);
    check("done_gen", gc_mn, 2);
    check("done_out_valid", ov_mn, 0);
    check_best_sm("done");

    // Reset after 3 of 4 inputs, then a fresh generation
    @(negedge clk); rst_sm = 1'b1;
    @(negedge clk); rst_sm = 1'b0;
    model_reset(0); model_reset(1);
    for (int i = 0; i < 3; i++) push_sm(CW'($urandom), FW'($urandom_range(0, 9)));
    @(negedge clk);
    #2;
    rst_sm = 1'b1;
    #1;
    check("mid_rst_bv_mn", bv_mn, 0);
    check("mid_rst_bv_mx", bv_mx, 0);
    check("mid_rst_bc", bc_mn, 0);
    check("mid_rst_gen", gc_mn, 0);
    check("mid_rst_out_valid", ov_mn, 0);
    model_reset(0); model_reset(1);
    @(negedge clk);
    rst_sm = 1'b0;
    for (int i = 0; i < 4; i++) push_sm(CW'($urandom), FW'($urandom_range(0, 9)));
    pop_sm("r1s0", c0, c1);
    pop_sm("r1s1", c0, c1);
    check_best_sm("r1");
    check("r1_gen", gc_mn, 1);

    // Large instance: random gaps on both sides
    sent = 0; got = 0; cyc = 0;
    @(negedge clk);
    rst_bg = 1'b0;
    while (got < int'(BP / 2 * BG) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      iv_bg = (sent < int'(BP * BG)) && ($urandom_range(0, 3) != 0);
      ic_bg = CW'($urandom);
      if_bg = FW'($urandom_range(0, 20));
      or_bg = ($urandom_range(0, 2) != 0);
      #1;
      check("bg_exclusive", ir_bg && ov_bg, 0);
      if (iv_bg && ir_bg) begin
        model_accept(2, BP, ic_bg, if_bg);
        sent++;
      end
      if (ov_bg && or_bg) begin
        if (exp_q[2].size() == 0) check("bg_extra", 1, 0);
        else begin
          e = exp_q[2].pop_front();
          check("bg_chrom", oc_bg, e[CW+FW-1:FW]);
          check("bg_fit", of_bg, e[FW-1:0]);
        end
        got++;
      end
    end
    if (got < int'(BP / 2 * BG)) check("bg_timeout", 64'(got), 64'(BP / 2 * BG));
    @(negedge clk);
    iv_bg = 1'b0; or_bg = 1'b0;
    #1;
    check("bg_gen", gc_bg, BG);
    check("bg_done", dn_bg, 1);
    check("bg_bv", bv_bg, mb_v[2]);
    check("bg_bc", bc_bg, mb_c[2]);
    check("bg_bf", bf_bg, mb_f[2]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ga_tournament_buf.md
GA_TOURNAMENT_BUF -- requirements
Module: ga_tournament_buf

Interface
REQ-001 SHALL have parameter POP_SIZE, default 32, individuals per generation (power of 2, >= 4).
REQ-002 SHALL have parameter CHROM_WIDTH, default 16, chromosome width.
REQ-003 SHALL have parameter FITNESS_WIDTH, default (CHROM_WIDTH+1)*3, fitness width (unsigned).
REQ-004 SHALL have parameter GENS, default 100, generations before done.
REQ-005 SHALL have parameter MAXIMIZE, default 0, where 0 means lower fitness wins and 1 means higher fitness wins.
REQ-006 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-008 SHALL have port in_valid, input, 1, an individual is offered.
REQ-009 SHALL have port in_ready, output, 1, the block accepts an individual.
REQ-010 SHALL have port in_chrom, input, CHROM_WIDTH, offered chromosome.
REQ-011 SHALL have port in_fit, input, FITNESS_WIDTH, fitness of in_chrom.
REQ-012 SHALL have port out_valid, output, 1, a tournament winner is presented.
REQ-013 SHALL have port out_ready, input, 1, the consumer takes the winner.
REQ-014 SHALL have port out_chrom, output, CHROM_WIDTH, winner chromosome.
REQ-015 SHALL have port out_fit, output, FITNESS_WIDTH, winner fitness.
REQ-016 SHALL have port best_chrom, output, CHROM_WIDTH, best-ever chromosome.
REQ-017 SHALL have port best_fit, output, FITNESS_WIDTH, best-ever fitness.
REQ-018 SHALL have port best_valid, output, 1, best_* holds a real individual.
REQ-019 SHALL have port gen_count, output, $clog2(GENS+1), completed generations.
REQ-020 SHALL have port done, output, 1, all GENS generations are complete.

Function
REQ-021 SHALL implement FSM states FILL, EMIT and DONE.
REQ-022 SHALL drive in_ready=1 only in FILL; an input transfer occurs when in_valid && in_ready on a clk edge.
REQ-023 SHALL number accepted individuals 0..POP_SIZE-1 per generation; on accepting odd index 2k+1 it SHALL compare it with stored index 2k and write the winner to winner slot k (POP_SIZE/2 slots).
REQ-024 SHALL select the winner as: MAXIMIZE=0 -> even if fit_even < fit_odd, else odd; MAXIMIZE=1 -> even if fit_even > fit_odd, else odd. Ties therefore go to the odd individual.
REQ-025 SHALL update best_chrom/best_fit and set best_valid on any accepted individual when best_valid=0 or its fitness is strictly better than best_fit; ties keep the old best.
REQ-026 SHALL move FILL->EMIT on the edge that accepts index POP_SIZE-1; out_valid SHALL assert in the next cycle (1-cycle latency).
REQ-027 SHALL present winners in EMIT in slot order 0..POP_SIZE/2-1; out_chrom/out_fit SHALL be stable while out_valid=1 and out_ready=0.
REQ-028 SHALL, on the transfer of the last slot, increment gen_count; if gen_count reaches GENS the FSM SHALL go to DONE, else to FILL with the index reset to 0.
REQ-029 SHALL in DONE hold done=1, in_ready=0, out_valid=0, and keep best_* and gen_count until reset.
REQ-030 SHALL ignore in_valid outside FILL and out_ready outside EMIT.
REQ-031 SHALL keep the best-ever value across generations; it is never cleared except by reset.

Reset
REQ-032 SHALL, while reset=1 (asynchronously), force state FILL, index 0, slot pointer 0, in_ready=1 after release, out_valid=0, out_chrom=0, out_fit=0, best_chrom=0, best_fit=0, best_valid=0, gen_count=0, done=0.
REQ-033 SHALL, on reset mid-FILL or mid-EMIT, discard the partial generation; winner slot contents need not be cleared.

Structure
REQ-034 SHALL place the FSM state enum and the fitness-compare function (MAXIMIZE-aware "better" predicate) in shared package ga_pkg.
REQ-035 SHALL place the POP_SIZE/2 winner storage in sub-module ga_winner_mem (1 write port, 1 read port, registered read); all other logic SHALL be in ga_tournament_buf.

Verification
REQ-036 SHALL test POP_SIZE=4, MAXIMIZE=0, inputs (A1,5),(B2,3),(C3,7),(D4,7): out is B2/3 then D4/7 (tie goes to odd), best is B2/3.
REQ-037 SHALL test the same inputs with MAXIMIZE=1: out is A1/5 then D4/7 (tie goes to odd), best is C3/7 (first of tie kept).
REQ-038 SHALL test out_ready held low for 5 cycles during EMIT: out_valid stays 1, data stays stable, and in_ready stays 0.
REQ-039 SHALL test GENS=2 with full traffic: gen_count goes 1 then 2, done=1, and further in_valid is not accepted.
REQ-040 SHALL test reset asserted after 3 of 4 inputs and then a fresh generation: outputs reflect only the post-reset inputs and best_valid is 0 immediately after reset.
REQ-041 SHALL test random in_valid/out_ready gaps with POP_SIZE=32: the scoreboard's winner stream and best_* match the reference model.
